// File: rtl/pbvi_pkg.sv
// ---------------------------------------------------------------------------
// pbvi_pkg
// Shared definitions for the PBVI solver: problem dimensions, the sequencer
// state encoding and the belief/alpha storage types used by the step1..step3
// datapath blocks.
// ---------------------------------------------------------------------------
package pbvi_pkg;

  localparam int N_POINTS  = 16;
  localparam int N_STATES  = 2;
  localparam int N_ACTIONS = 3;
  localparam int DATA_W    = 16;
  localparam int ACT_W     = $clog2(N_ACTIONS);

  // IDLE must encode as 0 so state_o reads 0 out of reset.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN1  = 3'd1,
    S_RUN2  = 3'd2,
    S_RUN3  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } pbvi_state_e;

  typedef logic [DATA_W-1:0]                 pbvi_data_t;
  typedef pbvi_data_t [N_STATES-1:0]         belief_t;
  typedef belief_t    [N_POINTS-1:0]         belief_arr_t;
  typedef pbvi_data_t [N_STATES-1:0]         alpha_vec_t;
  typedef alpha_vec_t [N_POINTS-1:0]         alpha_arr_t;
  typedef logic [ACT_W-1:0]                  action_t;
  typedef action_t    [N_POINTS-1:0]         point_action_arr_t;

  function automatic logic is_run(input pbvi_state_e s);
    return (s == S_RUN1) || (s == S_RUN2) || (s == S_RUN3);
  endfunction

  function automatic logic is_busy(input pbvi_state_e s);
    return is_run(s) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/pbvi_iter_ctrl_if.sv
// ---------------------------------------------------------------------------
// pbvi_iter_ctrl_if
// Control/handshake bundle between the PBVI sequencer and its environment
// (host request side plus the three stage blocks).
//   slave  : the sequencer (receives start/abort/done, drives en/status)
//   master : host + stage blocks
// ---------------------------------------------------------------------------
interface pbvi_iter_ctrl_if
  import pbvi_pkg::*;
#(
  parameter int ITER_W = 8
);
  logic                           start;
  logic                           abort;
  logic [ITER_W-1:0]              max_iter;
  logic                           step1_en;
  logic                           step2_en;
  logic                           step3_en;
  logic                           step1_done;
  logic                           step2_done;
  logic                           step3_done;
  logic                           step3_en_loop;
  logic                           alpha_we;
  logic                           busy;
  logic                           done;
  logic                           converged;
  logic                           timeout_err;
  logic [ITER_W-1:0]              iter_cnt;
  logic [$bits(pbvi_state_e)-1:0] state_o;

  modport slave (
    input  start, abort, max_iter,
    input  step1_done, step2_done, step3_done, step3_en_loop,
    output step1_en, step2_en, step3_en, alpha_we,
    output busy, done, converged, timeout_err, iter_cnt, state_o
  );

  modport master (
    output start, abort, max_iter,
    output step1_done, step2_done, step3_done, step3_en_loop,
    input  step1_en, step2_en, step3_en, alpha_we,
    input  busy, done, converged, timeout_err, iter_cnt, state_o
  );

endinterface

// File: rtl/pbvi_stage_timer.sv
// ---------------------------------------------------------------------------
// pbvi_stage_timer
// Per-stage watchdog. Down-counter loaded on i_clear, decremented while
// i_run; o_expired flags the last cycle of a TIMEOUT-cycle window.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_clear     : reload for a new stage (wins over i_run)
//   i_run       : stage active this cycle
//   o_expired   : i_run and the window has been used up
// ---------------------------------------------------------------------------
module pbvi_stage_timer #(
  parameter int TIMEOUT = 1024,
  parameter int TMR_W   = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  logic [TMR_W-1:0] r_cnt;

  // Loaded with TIMEOUT-1 so that the stage's entry cycle counts as the
  // first of its TIMEOUT allowed cycles; the count hits zero on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= TMR_W'(TIMEOUT - 1);
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end
  end

  assign o_expired = i_run && (r_cnt == '0);

endmodule

// File: rtl/pbvi_iter_ctrl.sv
// ---------------------------------------------------------------------------
// pbvi_iter_ctrl
// Top-level value-iteration sequencer for the PBVI datapath. Runs
// step1 -> step2 -> step3 per sweep, commits alpha in CHECK and decides
// whether to sweep again (en_loop), stop (cap) or fault (stage timeout).
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for start
//   RUN1   | step1 active (en on first cycle)
//   RUN2   | step2 active
//   RUN3   | step3 active, en_loop captured with its done
//   CHECK  | one cycle: alpha commit, iteration count, loop decision
//   DONE   | solve finished (converged or capped)
//   ERROR  | a stage overran its timeout
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : pbvi_iter_ctrl_if.slave (start/abort/max_iter, stage
//              en/done handshakes, alpha_we, status and debug state)
// ---------------------------------------------------------------------------
module pbvi_iter_ctrl
  import pbvi_pkg::*;
#(
  parameter int ITER_W  = 8,
  parameter int TIMEOUT = 1024,
  parameter int TMR_W   = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  pbvi_iter_ctrl_if.slave         bus
);

  pbvi_state_e       r_state;
  pbvi_state_e       w_next;
  logic              r_entry;
  logic [ITER_W-1:0] r_iter;
  logic [ITER_W-1:0] r_cap;
  logic              r_loop;
  logic              r_conv;
  logic              r_tmo;

  logic              w_entry;
  logic              w_run;
  logic              w_expired;
  logic              w_start_acc;
  logic              w_iter_inc;
  logic              w_latch_loop;
  logic              w_set_conv;
  logic              w_set_tmo;
  logic [ITER_W-1:0] w_iter_next;
  logic [2:0]        w_step_en;
  logic              w_alpha_we;

  assign w_run       = is_run(r_state);
  assign w_iter_next = (r_iter == '1) ? r_iter : r_iter + ITER_W'(1);

  // Every RUNx is entered from a different state, so a change of state into
  // a RUN state marks the stage start (timer reload + en pulse next cycle).
  assign w_entry = is_run(w_next) && (w_next != r_state);

  pbvi_stage_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_entry),
    .i_run     (w_run),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A done arriving with the en pulse (r_entry) is not accepted. Done is
  // tested before expiry so a completion on the last allowed cycle wins.
  always_comb begin
    w_next       = r_state;
    w_step_en    = 3'b000;
    w_alpha_we   = 1'b0;
    w_start_acc  = 1'b0;
    w_iter_inc   = 1'b0;
    w_latch_loop = 1'b0;
    w_set_conv   = 1'b0;
    w_set_tmo    = 1'b0;

    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            w_next      = S_RUN1;
            w_start_acc = 1'b1;
          end
        end
        S_RUN1: begin
          w_step_en[0] = r_entry;
          if (!r_entry && bus.step1_done) begin
            w_next = S_RUN2;
          end else if (w_expired) begin
            w_next    = S_ERROR;
            w_set_tmo = 1'b1;
          end
        end
        S_RUN2: begin
          w_step_en[1] = r_entry;
          if (!r_entry && bus.step2_done) begin
            w_next = S_RUN3;
          end else if (w_expired) begin
            w_next    = S_ERROR;
            w_set_tmo = 1'b1;
          end
        end
        S_RUN3: begin
          w_step_en[2] = r_entry;
          if (!r_entry && bus.step3_done) begin
            w_next       = S_CHECK;
            w_latch_loop = 1'b1;
          end else if (w_expired) begin
            w_next    = S_ERROR;
            w_set_tmo = 1'b1;
          end
        end
        S_CHECK: begin
          w_alpha_we = 1'b1;
          w_iter_inc = 1'b1;
          if (!r_loop) begin
            w_next     = S_DONE;
            w_set_conv = 1'b1;
          end else if (w_iter_next == r_cap) begin
            w_next = S_DONE;
          end else begin
            w_next = S_RUN1;
          end
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end

    // The reset cycle must not leak a pulse from the state being discarded.
    if (rst) begin
      w_step_en  = 3'b000;
      w_alpha_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry <= 1'b0;
      r_iter  <= '0;
      r_cap   <= '0;
      r_loop  <= 1'b0;
      r_conv  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_entry <= w_entry;
      if (w_start_acc) begin
        r_iter <= '0;
        r_cap  <= (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
        r_loop <= 1'b0;
        r_conv <= 1'b0;
        r_tmo  <= 1'b0;
      end
      if (w_iter_inc) begin
        r_iter <= w_iter_next;
      end
      if (w_latch_loop) begin
        r_loop <= bus.step3_en_loop;
      end
      if (w_set_conv) begin
        r_conv <= 1'b1;
      end
      if (w_set_tmo) begin
        r_tmo <= 1'b1;
      end
      if (bus.abort) begin
        r_conv <= 1'b0;
      end
    end
  end

  assign bus.step1_en    = w_step_en[0];
  assign bus.step2_en    = w_step_en[1];
  assign bus.step3_en    = w_step_en[2];
  assign bus.alpha_we    = w_alpha_we;
  assign bus.busy        = is_busy(r_state);
  assign bus.done        = (r_state == S_DONE);
  assign bus.converged   = r_conv && (r_state == S_DONE);
  assign bus.timeout_err = r_tmo;
  assign bus.iter_cnt    = r_iter;
  assign bus.state_o     = r_state;

endmodule

// File: tb/tb_pbvi_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pbvi_iter_ctrl
// Directed bench for the PBVI sequencer. Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point (settled state).
// ---------------------------------------------------------------------------
module tb_pbvi_iter_ctrl;

  localparam int ITER_W  = 8;
  localparam int TIMEOUT = 1024;
  localparam int TMR_W   = 11;

  localparam logic [31:0] ST_IDLE  = 32'd0;
  localparam logic [31:0] ST_RUN1  = 32'd1;
  localparam logic [31:0] ST_RUN2  = 32'd2;
  localparam logic [31:0] ST_RUN3  = 32'd3;
  localparam logic [31:0] ST_CHECK = 32'd4;
  localparam logic [31:0] ST_DONE  = 32'd5;
  localparam logic [31:0] ST_ERROR = 32'd6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pbvi_iter_ctrl_if #(.ITER_W(ITER_W)) bus_if ();

  pbvi_iter_ctrl #(
    .ITER_W  (ITER_W),
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_alpha = 0;
  int en_log[$];
  int a0;

  always @(negedge clk) begin
    if (bus_if.alpha_we) n_alpha++;
    if (bus_if.step1_en) en_log.push_back(1);
    if (bus_if.step2_en) en_log.push_back(2);
    if (bus_if.step3_en) en_log.push_back(3);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic en_of(input int k);
    case (k)
      1:       return bus_if.step1_en;
      2:       return bus_if.step2_en;
      default: return bus_if.step3_en;
    endcase
  endfunction

  task automatic set_done(input int k, input logic v);
    case (k)
      1:       bus_if.step1_done = v;
      2:       bus_if.step2_done = v;
      default: bus_if.step3_done = v;
    endcase
  endtask

  // Called in the en cycle of stage k; returns in the cycle after done.
  task automatic run_stage(input int k, input logic lf);
    check($sformatf("step%0d_en", k), en_of(k), 1);
    repeat (3) cyc();
    set_done(k, 1'b1);
    if (k == 3) bus_if.step3_en_loop = lf;
    cyc();
    set_done(k, 1'b0);
    bus_if.step3_en_loop = 1'b0;
  endtask

  task automatic sweep(input logic lf);
    run_stage(1, 1'b0);
    run_stage(2, 1'b0);
    run_stage(3, lf);
    check("check_state", bus_if.state_o, ST_CHECK);
    check("check_alpha_we", bus_if.alpha_we, 1);
    cyc();
  endtask

  task automatic start_solve(input logic [ITER_W-1:0] mi);
    bus_if.max_iter = mi;
    bus_if.start    = 1'b1;
    cyc();
    bus_if.start    = 1'b0;
  endtask

  initial begin
    rst                  = 1'b1;
    bus_if.start         = 1'b0;
    bus_if.abort         = 1'b0;
    bus_if.max_iter      = '0;
    bus_if.step1_done    = 1'b0;
    bus_if.step2_done    = 1'b0;
    bus_if.step3_done    = 1'b0;
    bus_if.step3_en_loop = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Reset values
    check("rst_state", bus_if.state_o, ST_IDLE);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_conv", bus_if.converged, 0);
    check("rst_tmo", bus_if.timeout_err, 0);
    check("rst_iter", bus_if.iter_cnt, 0);
    check("rst_en", {bus_if.step1_en, bus_if.step2_en, bus_if.step3_en, bus_if.alpha_we}, 0);

    // Converge in one sweep
    en_log.delete();
    a0 = n_alpha;
    start_solve(8'd5);
    check("t1_busy", bus_if.busy, 1);
    sweep(1'b0);
    check("t1_done", bus_if.done, 1);
    check("t1_conv", bus_if.converged, 1);
    check("t1_iter", bus_if.iter_cnt, 1);
    check("t1_busy_end", bus_if.busy, 0);
    check("t1_alpha_cnt", n_alpha - a0, 1);
    check("t1_en_cnt", en_log.size(), 3);
    check("t1_order0", en_log[0], 1);
    check("t1_order1", en_log[1], 2);
    check("t1_order2", en_log[2], 3);
    cyc();
    check("t1_done_held", bus_if.done, 1);

    // Iteration cap of 3
    a0 = n_alpha;
    start_solve(8'd3);
    check("t2_done_cleared", bus_if.done, 0);
    check("t2_conv_cleared", bus_if.converged, 0);
    sweep(1'b1);
    check("t2_iter_a", bus_if.iter_cnt, 1);
    sweep(1'b1);
    sweep(1'b1);
    check("t2_done", bus_if.done, 1);
    check("t2_conv", bus_if.converged, 0);
    check("t2_iter", bus_if.iter_cnt, 3);
    check("t2_alpha_cnt", n_alpha - a0, 3);

    // max_iter = 0 behaves as a cap of 1
    start_solve(8'd0);
    sweep(1'b1);
    check("t2b_done", bus_if.done, 1);
    check("t2b_conv", bus_if.converged, 0);
    check("t2b_iter", bus_if.iter_cnt, 1);

    // Timeout in RUN2
    a0 = n_alpha;
    start_solve(8'd5);
    run_stage(1, 1'b0);
    check("t3_step2_en", bus_if.step2_en, 1);
    repeat (TIMEOUT - 1) cyc();
    check("t3_still_run2", bus_if.state_o, ST_RUN2);
    cyc();
    check("t3_state", bus_if.state_o, ST_ERROR);
    check("t3_tmo", bus_if.timeout_err, 1);
    check("t3_busy", bus_if.busy, 0);
    check("t3_done", bus_if.done, 0);
    check("t3_alpha", n_alpha - a0, 0);
    start_solve(8'd1);
    check("t3_tmo_cleared", bus_if.timeout_err, 0);
    sweep(1'b1);
    check("t3_rerun_done", bus_if.done, 1);
    check("t3_rerun_iter", bus_if.iter_cnt, 1);

    // Abort in RUN3 together with step3_done
    start_solve(8'd5);
    sweep(1'b1);
    check("t4_iter_before", bus_if.iter_cnt, 1);
    run_stage(1, 1'b0);
    run_stage(2, 1'b0);
    check("t4_step3_en", bus_if.step3_en, 1);
    repeat (3) cyc();
    a0 = n_alpha;
    bus_if.step3_done    = 1'b1;
    bus_if.step3_en_loop = 1'b1;
    bus_if.abort         = 1'b1;
    cyc();
    bus_if.step3_done    = 1'b0;
    bus_if.step3_en_loop = 1'b0;
    bus_if.abort         = 1'b0;
    check("t4_state", bus_if.state_o, ST_IDLE);
    check("t4_busy", bus_if.busy, 0);
    check("t4_iter", bus_if.iter_cnt, 1);
    cyc();
    check("t4_alpha", n_alpha - a0, 0);

    // Handshake edges
    bus_if.max_iter   = 8'd5;
    bus_if.start      = 1'b1;
    cyc();
    bus_if.start      = 1'b0;
    bus_if.step1_done = 1'b1;
    check("t5_step1_en", bus_if.step1_en, 1);
    cyc();
    bus_if.step1_done = 1'b0;
    check("t5_coincident_done", bus_if.state_o, ST_RUN1);
    bus_if.step3_done = 1'b1;
    cyc();
    bus_if.step3_done = 1'b0;
    check("t5_stray_done", bus_if.state_o, ST_RUN1);
    bus_if.max_iter   = 8'd0;
    bus_if.start      = 1'b1;
    cyc();
    bus_if.start      = 1'b0;
    check("t5_start_busy_state", bus_if.state_o, ST_RUN1);
    check("t5_start_busy_en", bus_if.step1_en, 0);
    bus_if.step1_done = 1'b1;
    cyc();
    bus_if.step1_done = 1'b0;
    check("t5_step2_en", bus_if.step2_en, 1);
    repeat (TIMEOUT - 1) cyc();
    bus_if.step2_done = 1'b1;
    cyc();
    bus_if.step2_done = 1'b0;
    check("t5_expiry_done_state", bus_if.state_o, ST_RUN3);
    check("t5_expiry_done_tmo", bus_if.timeout_err, 0);
    run_stage(3, 1'b1);
    check("t5_alpha_we", bus_if.alpha_we, 1);
    cyc();
    check("t5_cap_kept", bus_if.step1_en, 1);
    bus_if.abort = 1'b1;
    cyc();
    bus_if.abort = 1'b0;
    check("t5_abort_idle", bus_if.state_o, ST_IDLE);

    // Synchronous reset while in CHECK
    start_solve(8'd5);
    sweep(1'b1);
    run_stage(1, 1'b0);
    run_stage(2, 1'b0);
    run_stage(3, 1'b1);
    check("t6_in_check", bus_if.state_o, ST_CHECK);
    rst = 1'b1;
    #1;
    check("t6_alpha_gated", bus_if.alpha_we, 0);
    a0 = n_alpha;
    cyc();
    rst = 1'b0;
    check("t6_state", bus_if.state_o, ST_IDLE);
    check("t6_outs", {bus_if.busy, bus_if.done, bus_if.converged, bus_if.timeout_err,
                      bus_if.step1_en, bus_if.step2_en, bus_if.step3_en, bus_if.alpha_we}, 0);
    check("t6_iter", bus_if.iter_cnt, 0);
    check("t6_alpha_cnt", n_alpha - a0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pbvi_iter_ctrl.md
Name: pbvi_iter_ctrl

Overview:
- Top-level sequencer for the PBVI solver datapath.
- Runs step1 → step2 → step3 once per value-iteration sweep over the 16 belief points (2 states, 3 actions).
- Uses step3's en_loop flag to decide whether to sweep again. Commits alpha after each sweep; stops on convergence, iteration cap, stage timeout or abort.

Parameters:
- ITER_W, 8, width of iteration counter and max_iter
- TIMEOUT, 1024, max cycles a stage may run after its enable before error
- TMR_W, 11, timer width; must satisfy 2^TMR_W > TIMEOUT

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a solve; ignored while busy
- abort  in  1  level; forces return to IDLE
- max_iter  in  ITER_W  sweep cap, sampled on accepted start; 0 treated as 1
- step1_en / step2_en / step3_en  out  1  one-cycle stage start pulses
- step1_done / step2_done / step3_done  in  1  one-cycle stage completion pulses
- step3_en_loop  in  1  valid with step3_done; 1 = alpha changed, sweep again
- alpha_we  out  1  one-cycle commit strobe for the alpha/point_action store
- busy  out  1  high in RUN1..CHECK
- done  out  1  high in DONE, held until next accepted start
- converged  out  1  valid while done; 1 = stopped on en_loop=0
- timeout_err  out  1  sticky; cleared on accepted start or rst
- iter_cnt  out  ITER_W  completed sweeps of current/last solve
- state_o  out  3  encoded FSM state, for debug

Behaviour:
- Reset: state IDLE; all outputs 0. iter_cnt, the latched cap and the timer are cleared.
- States: IDLE, RUN1, RUN2, RUN3, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start → RUN1.
  - Clear iter_cnt, done, converged and timeout_err.
  - Latch cap = (max_iter==0) ? 1 : max_iter.
- Entering RUNx: stepx_en=1 for exactly that first cycle; stage timer cleared.
- stepx_done is accepted only from the cycle after stepx_en. A done coincident with the en pulse is ignored.
- Stray done pulses from inactive stages are ignored.
- RUN1 + step1_done → RUN2; RUN2 + step2_done → RUN3.
- RUN3 + step3_done → CHECK; step3_en_loop is latched in the same cycle.
- CHECK lasts exactly 1 cycle:
  - alpha_we=1 and iter_cnt increments (saturating at all-ones).
  - Next state:
    - latched en_loop==0 → DONE, converged=1
    - else if new iter_cnt == cap → DONE, converged=0
    - else → RUN1
- Latency:
  - start at cycle T → step1_en at T+1.
  - stepN_done at T → next stage en at T+1.
  - step3_done at T → alpha_we at T+1 → step1_en or done=1 at T+2.
- Timeout: the timer counts every cycle in RUNx. On reaching TIMEOUT with no done: → ERROR, timeout_err=1, no alpha_we, done=0.
- A done in the same cycle the timer hits TIMEOUT wins (stage completes normally).
- abort (any state, highest priority after rst): next state IDLE.
  - No en or alpha_we pulses in that cycle.
  - busy, done and converged cleared; iter_cnt held; timeout_err held.
- abort and start in the same cycle: abort wins, start dropped.
- rst mid-solve: identical to the reset values above; no pulses emitted in the reset cycle.
- busy = state in {RUN1, RUN2, RUN3, CHECK}.

Decomposition:
- pbvi_pkg:
  - N_POINTS=16, N_STATES=2, N_ACTIONS=3, DATA_W=16.
  - typedef enum logic [2:0] pbvi_state_e for the FSM states.
  - Belief/alpha array typedefs shared with the step1..step3 blocks.
- One sub-module, pbvi_stage_timer: clear, run, expired output for TIMEOUT. Instantiated once, cleared on each stage entry.

Test Plan:
- Converge in one sweep: max_iter=5, start; each done 3 cycles after its en; step3_en_loop=0 → en order 1,2,3; one alpha_we; done=1, converged=1, iter_cnt=1.
- Iteration cap: max_iter=3, en_loop always 1 → three full sweeps, three alpha_we; done=1, converged=0, iter_cnt=3. max_iter=0 → exactly one sweep.
- Timeout: withhold step2_done → ERROR exactly TIMEOUT cycles after step2_en; timeout_err=1, no alpha_we, busy=0. Next start clears timeout_err and runs normally.
- Abort mid-RUN3, asserted together with step3_done → IDLE next cycle; no alpha_we; iter_cnt unchanged; busy=0.
- Handshake edges:
  - step1_done coincident with step1_en is ignored and stage stays RUN1.
  - step3_done while in RUN1 is ignored.
  - start while busy is ignored.
  - Timer expiry and done in the same cycle → normal progress.
- Sync reset asserted in CHECK → all outputs 0 the following cycle; no alpha_we pulse.
